control_with_reset: RTL and testbench

- Top-level sequencing controller for the ECG processing pipeline.
- After reset release, repeatedly walks through a fixed frame: load (stage 2), then stages 3..6 one after another, then a one-state gap.
- Drives a 2-bit state code plus one enable strobe per downstream stage (s2..s6).
- All outputs are registered. Sits between the board reset switch and the stage datapaths.

---
 rtl/ctrl_pkg.sv | 14 +
 rtl/control_with_reset_if.sv | 14 +
 rtl/stage_timer.sv | 34 +++
 rtl/control_with_reset.sv | 114 +++++++++++
 tb/tb_control_with_reset.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ECG pipeline sequencing controller.
package ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    localparam int unsigned NUM_RUN_STAGES = 4;
    localparam int unsigned TIMER_WIDTH    = 8;

endpackage

// File: rtl/control_with_reset_if.sv
// State code and per-stage enable strobes from the controller to the stage datapaths.
interface control_with_reset_if;

    logic [1:0] state;
    logic       s2;
    logic       s3;
    logic       s4;
    logic       s5;
    logic       s6;

    modport master (output state, s2, s3, s4, s5, s6);
    modport slave  (input  state, s2, s3, s4, s5, s6);

endinterface

// File: rtl/stage_timer.sv
// Loadable 8-bit down-counter that saturates at zero; done flags a zero count.
module stage_timer
    import ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   switch,
    input  logic                   load,
    input  logic [TIMER_WIDTH-1:0] load_value,
    output logic                   done
);

    logic [TIMER_WIDTH-1:0] count_q;
    logic [TIMER_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!switch) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/control_with_reset.sv
// Frame sequencer: IDLE -> LOAD (s2) -> RUN (s3..s6 in turn) -> DONE -> LOAD ...
// switch is a synchronous active-low reset; all outputs are registered.
module control_with_reset
    import ctrl_pkg::*;
#(
    parameter int unsigned LOAD_CYCLES  = 2,
    parameter int unsigned STAGE_CYCLES = 1,
    parameter int unsigned DONE_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 switch,
    control_with_reset_if.master bus
);

    localparam logic [TIMER_WIDTH-1:0] LOAD_VALUE  = TIMER_WIDTH'(LOAD_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] STAGE_VALUE = TIMER_WIDTH'(STAGE_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] DONE_VALUE  = TIMER_WIDTH'(DONE_CYCLES - 1);
    localparam logic [1:0]             LAST_STAGE  = 2'(NUM_RUN_STAGES - 1);

    state_e     state_q;
    state_e     state_d;
    logic [1:0] idx_q;
    logic [1:0] idx_d;
    logic [4:0] strobe_q;
    logic [4:0] strobe_d;

    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_done;

    stage_timer u_stage_timer (
        .clk        (clk),
        .switch     (switch),
        .load       (timer_load),
        .load_value (timer_value),
        .done       (timer_done)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_load  = 1'b0;
        timer_value = '0;
        unique case (state_q)
            ST_IDLE: begin
                state_d     = ST_LOAD;
                timer_load  = 1'b1;
                timer_value = LOAD_VALUE;
            end
            ST_LOAD: begin
                if (timer_done) begin
                    state_d     = ST_RUN;
                    idx_d       = 2'd0;
                    timer_load  = 1'b1;
                    timer_value = STAGE_VALUE;
                end
            end
            ST_RUN: begin
                if (timer_done) begin
                    timer_load = 1'b1;
                    if (idx_q == LAST_STAGE) begin
                        state_d     = ST_DONE;
                        idx_d       = 2'd0;
                        timer_value = DONE_VALUE;
                    end else begin
                        idx_d       = idx_q + 2'd1;
                        timer_value = STAGE_VALUE;
                    end
                end
            end
            ST_DONE: begin
                if (timer_done) begin
                    state_d     = ST_LOAD;
                    timer_load  = 1'b1;
                    timer_value = LOAD_VALUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Strobes decode the next state so they land in the same cycle as the state code.
    always_comb begin
        strobe_d = 5'b00000;
        case (state_d)
            ST_LOAD: strobe_d = 5'b10000;
            ST_RUN:  strobe_d = 5'b01000 >> idx_d;
            default: strobe_d = 5'b00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!switch) begin
            state_q  <= ST_IDLE;
            idx_q    <= 2'd0;
            strobe_q <= 5'b00000;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.state = state_q;
    assign bus.s2    = strobe_q[4];
    assign bus.s3    = strobe_q[3];
    assign bus.s4    = strobe_q[2];
    assign bus.s5    = strobe_q[1];
    assign bus.s6    = strobe_q[0];

endmodule

// File: tb/tb_control_with_reset.sv
// Scoreboard bench: a default-parameter controller and a (3,2,2) one share clk and switch.
module tb_control_with_reset;

    logic clk = 1'b0;
    logic switch = 1'b0;
    int   k = 0;
    int   vectors = 0;
    int   miscompares = 0;

    logic [6:0] q_a[$];
    logic [6:0] q_b[$];
    logic [6:0] obs_a;
    logic [6:0] obs_b;

    always #5 clk = ~clk;

    control_with_reset_if ifa ();
    control_with_reset_if ifb ();

    control_with_reset dut_a (
        .clk    (clk),
        .switch (switch),
        .bus    (ifa.master)
    );

    control_with_reset #(
        .LOAD_CYCLES  (3),
        .STAGE_CYCLES (2),
        .DONE_CYCLES  (2)
    ) dut_b (
        .clk    (clk),
        .switch (switch),
        .bus    (ifb.master)
    );

    assign obs_a = {ifa.state, ifa.s2, ifa.s3, ifa.s4, ifa.s5, ifa.s6};
    assign obs_b = {ifb.state, ifb.s2, ifb.s3, ifb.s4, ifb.s5, ifb.s6};

    // Expected {state, s2..s6} after the k-th consecutive edge sampling switch=1.
    function automatic logic [6:0] model(input int kk, input int lc, input int sc, input int dc);
        int p;
        logic [4:0] one;
        if (kk == 0) return 7'b00_00000;
        p = (kk - 1) % (lc + 4 * sc + dc);
        if (p < lc) return 7'b01_10000;
        if (p < lc + 4 * sc) begin
            one = 5'b01000 >> ((p - lc) / sc);
            return {2'b10, one};
        end
        return 7'b11_00000;
    endfunction

    task automatic tick(input logic sw);
        switch = sw;
        k = sw ? k + 1 : 0;
        q_a.push_back(model(k, 2, 1, 1));
        q_b.push_back(model(k, 3, 2, 2));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] ea, eb;
        for (int i = 0; i < 8; i++) begin
            tick(1'b0);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            vectors += 2;
            if (obs_a !== ea || ea !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_a edge %0d: got %b want %b", i, obs_a, 7'b0);
            end
            if (obs_b !== eb || eb !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_b edge %0d: got %b want %b", i, obs_b, 7'b0);
            end
        end
    endtask

    task automatic test_release();
        logic [6:0] ea, eb;
        logic [6:0] table_a [0:7];
        table_a = '{7'b01_10000, 7'b01_10000, 7'b10_01000, 7'b10_00100,
                    7'b10_00010, 7'b10_00001, 7'b11_00000, 7'b01_10000};
        for (int i = 0; i < 14; i++) begin
            tick(1'b1);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            vectors += 2;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL release_a k=%0d: got %b want %b", k, obs_a, ea);
            end
            if (obs_b !== eb) begin
                miscompares++;
                $display("FAIL release_b k=%0d: got %b want %b", k, obs_b, eb);
            end
            if (i < 8) begin
                vectors++;
                if (obs_a !== table_a[i]) begin
                    miscompares++;
                    $display("FAIL release_table k=%0d: got %b want %b", k, obs_a, table_a[i]);
                end
            end
        end
    endtask

    task automatic test_midframe_reset();
        logic [6:0] ea, eb;
        bit found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1'b1);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            vectors++;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL seek_s4 k=%0d: got %b want %b", k, obs_a, ea);
            end
            found = (ifa.s4 === 1'b1);
        end
        if (!found) begin
            miscompares++;
            $display("FAIL seek_s4: s4 got 0 want 1 within 20 cycles");
        end
        for (int i = 0; i < 8; i++) begin
            tick(i == 0 ? 1'b0 : 1'b1);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            vectors += 2;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL midreset_a step %0d: got %b want %b", i, obs_a, ea);
            end
            if (obs_b !== eb) begin
                miscompares++;
                $display("FAIL midreset_b step %0d: got %b want %b", i, obs_b, eb);
            end
        end
    endtask

    task automatic test_params();
        logic [6:0] ea, eb;
        int n_s2 = 0, n_s3 = 0, n_s4 = 0, n_s5 = 0, n_s6 = 0, n_done = 0;
        tick(1'b0);
        void'(q_a.pop_front());
        eb = q_b.pop_front();
        vectors++;
        if (obs_b !== eb) begin
            miscompares++;
            $display("FAIL params_reset: got %b want %b", obs_b, eb);
        end
        for (int i = 0; i < 26; i++) begin
            tick(1'b1);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            vectors += 2;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL params_a k=%0d: got %b want %b", k, obs_a, ea);
            end
            if (obs_b !== eb) begin
                miscompares++;
                $display("FAIL params_b k=%0d: got %b want %b", k, obs_b, eb);
            end
            n_s2 += int'(ifb.s2);
            n_s3 += int'(ifb.s3);
            n_s4 += int'(ifb.s4);
            n_s5 += int'(ifb.s5);
            n_s6 += int'(ifb.s6);
            n_done += int'(ifb.state == 2'b11);
        end
        vectors++;
        if (n_s2 != 6 || n_s3 != 4 || n_s4 != 4 || n_s5 != 4 || n_s6 != 4 || n_done != 4) begin
            miscompares++;
            $display("FAIL params_counts: got s2..s6/done %0d %0d %0d %0d %0d %0d want 6 4 4 4 4 4",
                     n_s2, n_s3, n_s4, n_s5, n_s6, n_done);
        end
    endtask

    task automatic test_continuous();
        logic [6:0] ea, eb;
        logic [1:0] prev_state;
        int last_entry = -1;
        bit ok_a, ok_b;
        prev_state = ifa.state;
        for (int i = 0; i < 350; i++) begin
            tick(1'b1);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            vectors += 4;
            if (obs_a !== ea) begin
                miscompares++;
                $display("FAIL cont_a k=%0d: got %b want %b", k, obs_a, ea);
            end
            if (obs_b !== eb) begin
                miscompares++;
                $display("FAIL cont_b k=%0d: got %b want %b", k, obs_b, eb);
            end
            ok_a = ($countones(obs_a[4:0]) <= 1) &&
                   (obs_a[4] ? obs_a[6:5] == 2'b01 : 1'b1) &&
                   ((obs_a[3:0] != 0) ? obs_a[6:5] == 2'b10 : 1'b1);
            ok_b = ($countones(obs_b[4:0]) <= 1) &&
                   (obs_b[4] ? obs_b[6:5] == 2'b01 : 1'b1) &&
                   ((obs_b[3:0] != 0) ? obs_b[6:5] == 2'b10 : 1'b1);
            if (ok_a !== 1'b1) begin
                miscompares++;
                $display("FAIL invariant_a k=%0d: got %b want consistent strobes", k, obs_a);
            end
            if (ok_b !== 1'b1) begin
                miscompares++;
                $display("FAIL invariant_b k=%0d: got %b want consistent strobes", k, obs_b);
            end
            if (prev_state == 2'b11 && ifa.state == 2'b01) begin
                if (last_entry >= 0) begin
                    vectors++;
                    if (i - last_entry != 7) begin
                        miscompares++;
                        $display("FAIL period: got %0d want 7", i - last_entry);
                    end
                end
                last_entry = i;
            end
            prev_state = ifa.state;
        end
        vectors++;
        if (last_entry < 0) begin
            miscompares++;
            $display("FAIL period: got no DONE->LOAD transition want one every 7 cycles");
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_midframe_reset();
        test_params();
        test_continuous();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
